// File: rtl/wb_arbiter_if.sv
// Bus bundle between the write-back arbiter and its producers/consumers:
// pipeline write-back, mul/div result handshake, register-file write port and hazard outputs.
interface wb_arbiter_if #(
    parameter int unsigned DEPTH = 2
);
    logic [31:0]              PIPE_DATA;
    logic [4:0]               PIPE_ADDR;
    logic                     PIPE_WE;
    logic [31:0]              MD_DATA;
    logic [4:0]               MD_ADDR;
    logic                     MD_VALID;
    logic                     MD_READY;
    logic [31:0]              REG_IN;
    logic [4:0]               REG_INADDRESS;
    logic                     REG_WRITE_EN;
    logic [31:0]              PENDING;
    logic [$clog2(DEPTH):0]   COUNT;

    modport master (
        output PIPE_DATA, PIPE_ADDR, PIPE_WE, MD_DATA, MD_ADDR, MD_VALID,
        input  MD_READY, REG_IN, REG_INADDRESS, REG_WRITE_EN, PENDING, COUNT
    );

    modport slave (
        input  PIPE_DATA, PIPE_ADDR, PIPE_WE, MD_DATA, MD_ADDR, MD_VALID,
        output MD_READY, REG_IN, REG_INADDRESS, REG_WRITE_EN, PENDING, COUNT
    );
endinterface

// File: rtl/wb_arbiter.sv
// Write-back arbiter: single writer of the register-file write port. Pipeline writes win;
// mul/div results that lose arbitration wait in a small FIFO with WAW kill on younger pipe writes.
module wb_arbiter #(
    parameter int unsigned DEPTH = 2
) (
    input  logic        CLK,
    input  logic        RESET,
    wb_arbiter_if.slave bus
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [DEPTH-1:0] r_live;
    logic [4:0]       r_addr [DEPTH];
    logic [31:0]      r_data [DEPTH];
    logic [PW-1:0]    r_rd_ptr;
    logic [PW-1:0]    r_wr_ptr;
    logic [CW-1:0]    r_count;
    logic [31:0]      r_reg_in;
    logic [4:0]       r_reg_addr;
    logic             r_reg_we;

    logic        w_md_ready;
    logic        w_md_acc;
    logic        w_md_nz;
    logic        w_pipe_eff;
    logic        w_empty;
    logic        w_pop;
    logic        w_bypass;
    logic        w_push;
    logic [31:0] w_pending;

    // No pop credit: a full FIFO refuses a result even on a cycle it drains.
    assign w_md_ready = !RESET && (r_count < CW'(DEPTH));
    assign w_md_acc   = bus.MD_VALID && w_md_ready;
    assign w_md_nz    = bus.MD_ADDR != 5'd0;
    assign w_pipe_eff = bus.PIPE_WE && (bus.PIPE_ADDR != 5'd0);
    assign w_empty    = r_count == '0;
    assign w_pop      = !w_pipe_eff && !w_empty;
    assign w_bypass   = !w_pipe_eff && w_empty && w_md_acc && w_md_nz;
    assign w_push     = w_md_acc && w_md_nz && !w_bypass;

    always_comb begin
        w_pending = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (r_live[i]) w_pending[r_addr[i]] = 1'b1;
        end
        w_pending[0] = 1'b0;
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_live     <= '0;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
            r_reg_in   <= '0;
            r_reg_addr <= '0;
            r_reg_we   <= 1'b0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_addr[i] <= '0;
                r_data[i] <= '0;
            end
        end else begin
            // Kill only entries already queued; a same-cycle push below is younger and survives.
            if (w_pipe_eff) begin
                for (int i = 0; i < int'(DEPTH); i++) begin
                    if (r_addr[i] == bus.PIPE_ADDR) r_live[i] <= 1'b0;
                end
            end

            if (w_pipe_eff) begin
                r_reg_we   <= 1'b1;
                r_reg_addr <= bus.PIPE_ADDR;
                r_reg_in   <= bus.PIPE_DATA;
            end else if (w_pop) begin
                r_reg_we <= r_live[r_rd_ptr];
                if (r_live[r_rd_ptr]) begin
                    r_reg_addr <= r_addr[r_rd_ptr];
                    r_reg_in   <= r_data[r_rd_ptr];
                end
            end else if (w_bypass) begin
                r_reg_we   <= 1'b1;
                r_reg_addr <= bus.MD_ADDR;
                r_reg_in   <= bus.MD_DATA;
            end else begin
                r_reg_we <= 1'b0;
            end

            if (w_pop) begin
                r_live[r_rd_ptr] <= 1'b0;
                r_rd_ptr         <= r_rd_ptr + 1'b1;
            end

            if (w_push) begin
                r_live[r_wr_ptr] <= 1'b1;
                r_addr[r_wr_ptr] <= bus.MD_ADDR;
                r_data[r_wr_ptr] <= bus.MD_DATA;
                r_wr_ptr         <= r_wr_ptr + 1'b1;
            end

            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    assign bus.MD_READY      = w_md_ready;
    assign bus.REG_IN        = r_reg_in;
    assign bus.REG_INADDRESS = r_reg_addr;
    assign bus.REG_WRITE_EN  = r_reg_we;
    assign bus.PENDING       = w_pending;
    assign bus.COUNT         = r_count;
endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed scenarios plus randomized traffic, every cycle compared
// against a queue-based reference model of the arbitration rules.
module tb_wb_arbiter;
    localparam int unsigned DEPTH = 2;

    typedef struct {
        bit        live;
        bit [4:0]  addr;
        bit [31:0] data;
    } ent_t;

    logic clk = 1'b0;
    logic rst;
    int   n_vec = 0;
    int   n_err = 0;

    ent_t      mq[$];
    bit        m_we;
    bit [4:0]  m_addr;
    bit [31:0] m_in;

    always #5 clk = ~clk;

    wb_arbiter_if #(.DEPTH(DEPTH)) bus ();

    wb_arbiter #(.DEPTH(DEPTH)) u_dut (
        .CLK   (clk),
        .RESET (rst),
        .bus   (bus)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %08h, expected %08h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic bit [31:0] model_pending();
        bit [31:0] p = '0;
        foreach (mq[i]) if (mq[i].live) p[mq[i].addr] = 1'b1;
        return p;
    endfunction

    task automatic check_state(input string ph);
        check_eq({ph, ".count"}, 32'(bus.COUNT), 32'(mq.size()));
        check_eq({ph, ".pending"}, bus.PENDING, model_pending());
        check_eq({ph, ".md_ready"}, 32'(bus.MD_READY), 32'(!rst && mq.size() < int'(DEPTH)));
    endtask

    task automatic drive_idle();
        bus.PIPE_WE   = 1'b0;
        bus.PIPE_ADDR = '0;
        bus.PIPE_DATA = '0;
        bus.MD_VALID  = 1'b0;
        bus.MD_ADDR   = '0;
        bus.MD_DATA   = '0;
    endtask

    // One clock of stimulus: drive at negedge, check combinational outputs, advance model, check.
    task automatic step(input bit pwe, input bit [4:0] pa, input bit [31:0] pd,
                        input bit mv, input bit [4:0] ma, input bit [31:0] md);
        bit   acc;
        bit   peff;
        ent_t e;
        @(negedge clk);
        bus.PIPE_WE   = pwe;
        bus.PIPE_ADDR = pa;
        bus.PIPE_DATA = pd;
        bus.MD_VALID  = mv;
        bus.MD_ADDR   = ma;
        bus.MD_DATA   = md;
        #1;
        check_state("pre");
        acc  = mv && (mq.size() < int'(DEPTH));
        peff = pwe && (pa != 5'd0);
        if (peff) begin
            foreach (mq[i]) if (mq[i].addr == pa) mq[i].live = 1'b0;
            m_we = 1'b1; m_addr = pa; m_in = pd;
            if (acc && ma != 5'd0) mq.push_back('{1'b1, ma, md});
        end else if (mq.size() != 0) begin
            e    = mq.pop_front();
            m_we = e.live;
            if (e.live) begin m_addr = e.addr; m_in = e.data; end
            if (acc && ma != 5'd0) mq.push_back('{1'b1, ma, md});
        end else if (acc && ma != 5'd0) begin
            m_we = 1'b1; m_addr = ma; m_in = md;
        end else begin
            m_we = 1'b0;
        end
        @(posedge clk);
        #1;
        check_eq("reg_we", 32'(bus.REG_WRITE_EN), 32'(m_we));
        check_eq("reg_addr", 32'(bus.REG_INADDRESS), 32'(m_addr));
        check_eq("reg_in", bus.REG_IN, m_in);
        check_state("post");
    endtask

    // Reset pulse between edges with requests still asserted; outputs must clear with no clock.
    task automatic async_reset();
        @(negedge clk);
        bus.PIPE_WE   = 1'b1;
        bus.PIPE_ADDR = 5'd4;
        bus.MD_VALID  = 1'b1;
        bus.MD_ADDR   = 5'd6;
        #2;
        rst = 1'b1;
        #1;
        mq.delete();
        m_we = 1'b0; m_addr = '0; m_in = '0;
        check_eq("rst.we", 32'(bus.REG_WRITE_EN), 32'd0);
        check_eq("rst.in", bus.REG_IN, 32'd0);
        check_eq("rst.addr", 32'(bus.REG_INADDRESS), 32'd0);
        check_state("rst");
        @(posedge clk);
        #1;
        check_eq("rst.hold_we", 32'(bus.REG_WRITE_EN), 32'd0);
        check_state("rst.hold");
        @(negedge clk);
        drive_idle();
        rst = 1'b0;
        #1;
        check_state("rst.rel");
    endtask

    initial begin
        int accepted;
        drive_idle();
        rst = 1'b1;
        mq.delete();
        m_we = 1'b0; m_addr = '0; m_in = '0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("init.we", 32'(bus.REG_WRITE_EN), 32'd0);
        check_state("init");
        @(negedge clk);
        rst = 1'b0;

        // Bypass into an empty FIFO.
        step(0, 0, 0, 1, 7, 32'hDEADBEEF);
        step(0, 0, 0, 0, 0, 0);

        // Contention, then drain in order.
        step(1, 3, 1, 1, 8, 32'hA);
        step(1, 3, 2, 1, 9, 32'hB);
        step(1, 3, 3, 0, 0, 0);
        check_eq("cont.pending", bus.PENDING, 32'h300);
        repeat (3) step(0, 0, 0, 0, 0, 0);

        // WAW kill of a queued x5.
        step(1, 3, 4, 1, 5, 32'h55);
        step(1, 5, 32'h66, 0, 0, 0);
        check_eq("waw.pending5", 32'(bus.PENDING[5]), 32'd0);
        repeat (2) step(0, 0, 0, 0, 0, 0);

        // x0 handling: discarded MD result, then a pipe x0 write lets the head drain.
        step(0, 0, 0, 1, 0, 32'h1);
        step(1, 3, 7, 1, 9, 32'h99);
        step(1, 0, 32'hBAD, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);

        // Async reset with a full FIFO and a live write on the port.
        step(1, 3, 8, 1, 10, 32'h10);
        step(1, 3, 9, 1, 11, 32'h11);
        async_reset();

        // Wrap and full: five results against mostly-busy pipe writes.
        accepted = 0;
        for (int i = 0; i < 40 && accepted < 5; i++) begin
            bit take;
            take = mq.size() < int'(DEPTH);
            step((i % 3) != 2, 5'd2, 32'(i), 1, 5'(12 + accepted), 32'h100 + 32'(accepted));
            if (take) accepted++;
        end
        repeat (3) step(0, 0, 0, 0, 0, 0);

        // Randomized traffic on a narrow address range so kills and x0 cases are frequent.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 299) == 0) async_reset();
            step($urandom_range(0, 9) < 6, 5'($urandom_range(0, 7)), $urandom,
                 $urandom_range(0, 9) < 5, 5'($urandom_range(0, 7)), $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
